pc_fetch_unit: RTL

//  Program-counter register plus instruction-fetch sequencer for the RV32I core.

---
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer.
// Ports: clk, rst_n, npc_i/redirect_i (next-PC mux), imem_* (instruction memory), if_* / id_ready_i (decode), fetch_misalign_o; optional MISALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] npc_i,
  input  logic            redirect_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            id_ready_i,
  output logic            fetch_misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            kill_q;
  logic [XLEN-1:0] npc_al;
  logic            bad_tgt;
  logic            halt;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  assign npc_al      = npc_i & ALIGN_MASK;
  assign pc_plus4_o  = pc_q + XLEN'(4);
  assign imem_addr_o = pc_q;
  assign imem_req_o  = (state_q == S_REQ);

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;

  assign bad_tgt          = redirect_i & (npc_i[1:0] != 2'b00);
  assign halt             = misalign_q;
  assign fetch_misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (bad_tgt) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign bad_tgt          = 1'b0;
  assign halt             = 1'b0;
  assign fetch_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_o <= 1'b0;
      if_instr_o <= '0;
      if_pc_o    <= '0;
    end else if (bad_tgt) begin
      // Bad target: park in IDLE, drop anything in flight.
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      if_valid_o <= 1'b0;
    end else if (halt) begin
      state_q <= S_IDLE;
    end else if (redirect_i) begin
      pc_q <= npc_al;
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (imem_gnt_i) begin
            state_q <= S_WAIT;
            kill_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          // Response arriving now is dropped and
          // nothing remains outstanding.
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
            kill_q  <= 1'b0;
          end else begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if_valid_o <= 1'b0;
          state_q    <= S_REQ;
        end
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (imem_gnt_i) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              if_instr_o <= imem_rdata_i;
              if_pc_o    <= pc_q;
              if_valid_o <= 1'b1;
              state_q    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready_i) begin
            if_valid_o <= 1'b0;
            pc_q       <= npc_al;
            state_q    <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule
